// File: rtl/rs485_pkg.sv
// rs485_pkg -- shared definitions for the RS-485 byte receiver.
//   CLKS_PER_BIT_DEFAULT : clk cycles per bit at 9600 baud
//   FRAME_BITS           : start + 8 data + parity + stop
//   rx_state_e           : receiver FSM state encoding
//   parity_of()          : parity of a data byte (XOR of all bits)
package rs485_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 2604;
    localparam int FRAME_BITS           = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    function automatic logic parity_of(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rs485_sync.sv
// rs485_sync -- brings the asynchronous serial line into the clk domain
// and flags its falling edges.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset; all flops reset to 1 so an
//             idle (high) line never looks like a start edge after reset
//   rx      : raw serial line
//   rx_s    : synchronised line (two flops)
//   rx_fall : one-cycle pulse when rx_s goes 1 -> 0
module rs485_sync
    import rs485_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s    = sync_q;
    // A line held low has prev_q = 0 too, so it never re-triggers.
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/rs485_rx.sv
// rs485_rx -- RS-485 / UART-style receiver, 8 data bits, even parity
// (parity bit = XOR of data), one stop bit, LSB first.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   rx         : serial line, idles high, asynchronous to clk
//   rx_ack     : consumer takes the held byte (single-cycle pulse)
//   rx_data    : last received byte
//   rx_vld     : a byte is held and has not been acknowledged
//   parity_err : held byte had a bad parity bit (qualified by rx_vld)
//   frame_err  : held byte had a 0 stop bit (qualified by rx_vld)
//   overrun    : a held byte was overwritten before it was acknowledged
//   rx_busy    : receiver FSM is inside a frame
module rs485_rx
    import rs485_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic rx_s;
    logic rx_fall;

    rs485_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_vld_q, rx_vld_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        rx_data_d    = rx_data_q;
        rx_vld_d     = rx_vld_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;

        // Acknowledge is only meaningful while a byte is held.
        if (rx_ack && rx_vld_q) begin
            rx_vld_d  = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    state_d    = ST_START;
                    baud_cnt_d = '0;
                end
            end

            ST_START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    // Line back high at mid-start: it was a glitch, drop it.
                    state_d    = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    // LSB arrives first, so after 8 right shifts d[0] sits at bit 0.
                    shift_d    = {rx_s, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            ST_PARITY: begin
                if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    par_d      = rx_s;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (baud_cnt_q == BIT_LAST) begin
                    // Leave at mid-stop so a following start edge is not missed.
                    baud_cnt_d   = '0;
                    state_d      = ST_IDLE;
                    rx_data_d    = shift_q;
                    parity_err_d = par_q ^ parity_of(shift_q);
                    frame_err_d  = ~rx_s;
                    rx_vld_d     = 1'b1;
                    // Same-cycle ack already cleared overrun above.
                    if (rx_vld_q && !rx_ack) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            rx_data_q    <= '0;
            rx_vld_q     <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            rx_data_q    <= rx_data_d;
            rx_vld_q     <= rx_vld_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_vld     = rx_vld_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rs485_rx.sv
// tb_rs485_rx -- self-checking bench for rs485_rx with a short bit time.
// Frames are driven bit by bit; expected outputs come from a byte-level
// model of the receiver's delivery/ack/overrun rules.
module tb_rs485_rx;
    import rs485_pkg::*;

    localparam int CPB  = 16;
    localparam int HALF = 8;
    // Edge (counted from the first edge that sees the start bit) at which
    // the delivered byte becomes visible: 2 sync stages, half a bit to the
    // start centre, then ten full bits to the stop centre.
    localparam int DONE_EDGE = 2 + HALF + (FRAME_BITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_data = 8'h00;
    logic       exp_vld  = 1'b0;
    logic       exp_perr = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr  = 1'b0;

    rs485_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, {24'd0, rx_data}, {24'd0, exp_data});
        check({tag, ".vld"},  {31'd0, rx_vld},     {31'd0, exp_vld});
        check({tag, ".perr"}, {31'd0, parity_err}, {31'd0, exp_perr});
        check({tag, ".ferr"}, {31'd0, frame_err},  {31'd0, exp_ferr});
        check({tag, ".ovr"},  {31'd0, overrun},    {31'd0, exp_ovr});
    endtask

    task automatic model_reset();
        exp_data = 8'h00;
        exp_vld  = 1'b0;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // Drive one full frame. ack_done pulses rx_ack in the completion cycle;
    // abort_at >= 0 asserts rst right after that edge and ends the frame.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp,
                              input logic ack_done, input int abort_at);
        logic [10:0] bits;
        bits = {stp, p, d, 1'b0};
        for (int n = 0; n < FRAME_BITS * CPB; n++) begin
            @(negedge clk);
            if (n % CPB == 0) rx = bits[n / CPB];
            if (ack_done && n == DONE_EDGE) rx_ack = 1'b1;
            @(posedge clk);
            #1;
            rx_ack = 1'b0;
            if (n == abort_at) begin
                rst = 1'b1;
                rx  = 1'b1;
                #1;
                model_reset();
                check_all("abort");
                check("abort.busy", {31'd0, rx_busy}, 32'd0);
                $display("frame d=%02h aborted by reset at edge %0d", d, n);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (n == DONE_EDGE - 1) begin
                check("pre.vld",  {31'd0, rx_vld},  {31'd0, exp_vld});
                check("pre.busy", {31'd0, rx_busy}, 32'd1);
            end
            if (n == DONE_EDGE) begin
                if (exp_vld) exp_ovr = ack_done ? 1'b0 : 1'b1;
                exp_vld  = 1'b1;
                exp_data = d;
                exp_perr = p ^ (^d);
                exp_ferr = ~stp;
                check_all("done");
                check("done.busy", {31'd0, rx_busy}, 32'd0);
                $display("frame d=%02h p=%0b s=%0b ack=%0b -> data=%02h vld=%0b perr=%0b ferr=%0b ovr=%0b",
                         d, p, stp, ack_done, rx_data, rx_vld, parity_err, frame_err, overrun);
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
        if (exp_vld) begin
            exp_vld = 1'b0;
            exp_ovr = 1'b0;
        end
        check("ack.vld", {31'd0, rx_vld},  {31'd0, exp_vld});
        check("ack.ovr", {31'd0, overrun}, {31'd0, exp_ovr});
        $display("ack -> vld=%0b ovr=%0b", rx_vld, overrun);
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        rx = 1'b1;
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        int hits;
        logic [7:0] d;
        logic       p;
        logic       s;
        int         mode;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.busy", {31'd0, rx_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2 * CPB);

        // Good frame, correct parity
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1);
        do_ack();
        do_ack();   // ack with nothing held is ignored

        // Parity error
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, -1);
        do_ack();

        // Frame error followed by a break
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
        do_ack();
        hits = 0;
        for (int i = 0; i < 5 * CPB; i++) begin
            @(posedge clk);
            #1;
            if (rx_vld || rx_busy) hits++;
        end
        check("break.quiet", hits, 0);
        $display("break held 5 bits -> activity cycles=%0d", hits);
        idle(2 * CPB);

        // Short low glitch on an idle line
        for (int n = 0; n < 3 * CPB; n++) begin
            @(negedge clk);
            rx = (n < 6) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (n == 2 + HALF - 1) check("glitch.busy1", {31'd0, rx_busy}, 32'd1);
            if (n == 2 + HALF)     check("glitch.busy0", {31'd0, rx_busy}, 32'd0);
        end
        check("glitch.vld", {31'd0, rx_vld}, 32'd0);
        $display("glitch 6 clks -> vld=%0b busy=%0b", rx_vld, rx_busy);

        // Back-to-back frames without ack, then ack in a completion cycle
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, -1);
        send_frame(8'h02, 1'b1, 1'b1, 1'b0, -1);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b1, -1);

        // Reset during d[4] with a byte still held, then a clean frame
        send_frame(8'h96, 1'b0, 1'b1, 1'b0, 2 + HALF + 4 * CPB + CPB / 2);
        idle(2 * CPB);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, -1);
        do_ack();

        // Randomised traffic against the model
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom);
            p    = (^d) ^ ($urandom_range(0, 3) == 0);
            s    = ($urandom_range(0, 4) != 0);
            mode = $urandom_range(0, 2);
            send_frame(d, p, s, (mode == 2), -1);
            if (mode == 0) do_ack();
            if (!s || $urandom_range(0, 1) == 1) idle(CPB * $urandom_range(1, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
